// File: rtl/lights_pkg.sv
// Shared definitions for the lights block and its advance sequencer.
package lights_pkg;

   typedef enum logic [1:0] {
      HOLD       = 2'b00,
      MANUAL     = 2'b01,
      AUTO_RUN   = 2'b10,
      AUTO_PAUSE = 2'b11
   } state_t;

   localparam logic [1:0] MODE_HOLD   = 2'b00;
   localparam logic [1:0] MODE_MANUAL = 2'b01;
   localparam logic [1:0] MODE_AUTO   = 2'b10;

   localparam logic [2:0] COLOUR_RED   = 3'b100;
   localparam logic [2:0] COLOUR_AMBER = 3'b010;
   localparam logic [2:0] COLOUR_GREEN = 3'b001;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer, counting debouncer and rising-edge press detector.
module button_debounce
   import lights_pkg::*;
#(
   parameter int unsigned DEBOUNCE = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic button_raw,
   output logic press
);

   localparam logic [7:0] DLAST = 8'(DEBOUNCE - 1);

   logic       sync1;
   logic       s;
   logic       db;
   logic       db_q;
   logic [7:0] dcnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= 1'b0;
         s     <= 1'b0;
         db    <= 1'b0;
         db_q  <= 1'b0;
         dcnt  <= '0;
      end else begin
         sync1 <= button_raw;
         s     <= sync1;
         db_q  <= db;
         // any sample agreeing with the filtered level restarts the run
         if (s == db) begin
            dcnt <= '0;
         end else if (dcnt == DLAST) begin
            db   <= s;
            dcnt <= '0;
         end else begin
            dcnt <= dcnt + 8'd1;
         end
      end
   end

   assign press = db & ~db_q;

endmodule

// File: rtl/lights_sequencer.sv
// Arbitrates hold/manual/auto sources into single-cycle advance pulses for lights.
module lights_sequencer
   import lights_pkg::*;
#(
   parameter int unsigned DEBOUNCE = 4,
   parameter int unsigned PERIOD_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                button_raw,
   input  logic [1:0]          mode,
   input  logic [PERIOD_W-1:0] period,
   output logic                advance,
   output logic [1:0]          state
);

   state_t              cur;
   state_t              nxt;
   logic [PERIOD_W-1:0] tcnt;
   logic                tzero;
   logic                press;
   logic                adv_d;

   button_debounce #(
      .DEBOUNCE(DEBOUNCE)
   ) u_debounce (
      .clk       (clk),
      .rst       (rst),
      .button_raw(button_raw),
      .press     (press)
   );

   assign tzero = (tcnt == '0);
   assign state = cur;

   always_comb begin
      nxt   = cur;
      adv_d = 1'b0;
      case (mode)
         MODE_MANUAL: nxt = MANUAL;
         MODE_AUTO: begin
            case (cur)
               AUTO_RUN:   nxt = press ? AUTO_PAUSE : AUTO_RUN;
               AUTO_PAUSE: nxt = press ? AUTO_RUN : AUTO_PAUSE;
               default:    nxt = AUTO_RUN;
            endcase
         end
         default: nxt = HOLD;
      endcase
      // requiring the state to persist drops presses that coincide with a
      // mode change and suppresses a pulse on the pause edge
      adv_d = ((cur == MANUAL) && (nxt == MANUAL) && press) ||
              ((cur == AUTO_RUN) && (nxt == AUTO_RUN) && tzero);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur     <= HOLD;
         tcnt    <= '0;
         advance <= 1'b0;
      end else begin
         cur     <= nxt;
         advance <= adv_d;
         if (nxt == AUTO_RUN) begin
            if ((cur != AUTO_RUN) || tzero) begin
               tcnt <= period;
            end else begin
               tcnt <= tcnt - PERIOD_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_lights_sequencer.sv
// Directed self-checking bench for lights_sequencer (DEBOUNCE=4, PERIOD_W=8).
module tb_lights_sequencer;

   logic       clk;
   logic       rst;
   logic       button_raw;
   logic [1:0] mode;
   logic [7:0] period;
   logic       advance;
   logic [1:0] state;

   int unsigned tests;
   int unsigned failed;
   int unsigned pulses;

   lights_sequencer #(
      .DEBOUNCE(4),
      .PERIOD_W(8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .button_raw(button_raw),
      .mode      (mode),
      .period    (period),
      .advance   (advance),
      .state     (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // advance to the sampling point after the next rising edge
   task automatic cyc();
      @(negedge clk);
   endtask

   initial begin
      tests      = 0;
      failed     = 0;
      rst        = 1'b0;
      button_raw = 1'b0;
      mode       = 2'b00;
      period     = 8'd3;
      repeat (3) cyc();
      check("reset_adv", {7'd0, advance}, 8'd0);
      check("reset_state", {6'd0, state}, 8'd0);

      // reserved mode behaves as hold
      rst  = 1'b1;
      mode = 2'b11;
      repeat (2) cyc();
      check("reserved_state", {6'd0, state}, 8'd0);

      // 1: manual, no button
      mode   = 2'b01;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         cyc();
         pulses += advance;
      end
      check("t1_pulses", pulses[7:0], 8'd0);
      check("t1_state", {6'd0, state}, 8'd1);

      // 2: held press gives one pulse after edge k+6
      button_raw = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cyc();
         check($sformatf("t2_hold_%0d", i), {7'd0, advance}, (i == 6) ? 8'd1 : 8'd0);
      end
      button_raw = 1'b0;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         cyc();
         pulses += advance;
      end
      check("t2_release", pulses[7:0], 8'd0);
      button_raw = 1'b1;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         cyc();
         pulses += advance;
         if (i == 6) check("t2_repress_at6", {7'd0, advance}, 8'd1);
      end
      check("t2_repress_cnt", pulses[7:0], 8'd1);
      button_raw = 1'b0;
      repeat (10) cyc();

      // 3: glitch of 3 samples rejected
      button_raw = 1'b1;
      repeat (3) cyc();
      button_raw = 1'b0;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         cyc();
         pulses += advance;
      end
      check("t3_glitch", pulses[7:0], 8'd0);

      // 4: auto cadence period=3, then period=1 after the next reload
      mode   = 2'b10;
      period = 8'd3;
      for (int i = 0; i <= 20; i++) begin
         cyc();
         if (i == 0) check("t4_entry_state", {6'd0, state}, 8'd2);
         check($sformatf("t4_adv_%0d", i), {7'd0, advance},
               (i == 4 || i == 8 || i == 12 || i == 16 || i == 18 || i == 20) ? 8'd1 : 8'd0);
         if (i == 13) period = 8'd1;
      end

      // 5: pause with a press, then resume
      button_raw = 1'b1;
      for (int i = 0; i <= 6; i++) begin
         cyc();
         check($sformatf("t5_prepause_%0d", i), {7'd0, advance},
               (i == 1 || i == 3 || i == 5) ? 8'd1 : 8'd0);
      end
      check("t5_paused_state", {6'd0, state}, 8'd3);
      button_raw = 1'b0;
      pulses = 0;
      for (int i = 0; i < 50; i++) begin
         cyc();
         pulses += advance;
      end
      check("t5_pause_pulses", pulses[7:0], 8'd0);
      check("t5_pause_state", {6'd0, state}, 8'd3);
      button_raw = 1'b1;
      for (int i = 0; i <= 12; i++) begin
         cyc();
         if (i == 5) check("t5_still_paused", {6'd0, state}, 8'd3);
         if (i == 6) check("t5_resumed", {6'd0, state}, 8'd2);
         check($sformatf("t5_resume_%0d", i), {7'd0, advance},
               (i == 8 || i == 10 || i == 12) ? 8'd1 : 8'd0);
      end
      button_raw = 1'b0;

      // 6: asynchronous reset between edges
      #2;
      rst = 1'b0;
      #1;
      check("t6_async_adv", {7'd0, advance}, 8'd0);
      check("t6_async_state", {6'd0, state}, 8'd0);
      mode = 2'b00;
      cyc();
      rst = 1'b1;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         pulses += advance;
      end
      check("t6_hold_pulses", pulses[7:0], 8'd0);
      check("t6_hold_state", {6'd0, state}, 8'd0);

      // period=0: pulse every cycle; leaving auto stops it at once
      mode   = 2'b10;
      period = 8'd0;
      for (int i = 0; i <= 5; i++) begin
         cyc();
         check($sformatf("p0_adv_%0d", i), {7'd0, advance}, (i == 0) ? 8'd0 : 8'd1);
      end
      mode = 2'b00;
      cyc();
      check("p0_exit_adv", {7'd0, advance}, 8'd0);
      check("p0_exit_state", {6'd0, state}, 8'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      failed++;
      $display("FAIL timeout: observed running expected finished");
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/lights_sequencer.md
# lights_sequencer

Controller that drives the `button` (advance) input of the `lights` block. It turns a noisy push-button and a mode selection into clean single-cycle advance pulses. Three sources are arbitrated: hold (no advance), manual (one step per debounced press) and auto (periodic steps, pausable by the button). It sits between the board button and the `lights` instance; its `advance` output connects directly to `lights.button`.

## Interface

Parameters:
- `DEBOUNCE` — default 4 — consecutive synchronized samples required to accept a button level change; legal range 2..255.
- `PERIOD_W` — default 8 — width of the auto-mode period input.

Ports:
- `clk` — input — 1 — single clock for all logic.
- `rst` — input — 1 — asynchronous, active-low reset (0 = reset asserted).
- `button_raw` — input — 1 — asynchronous push-button, active-high.
- `mode` — input — 2 — `00` hold, `01` manual, `10` auto, `11` reserved (treated as hold).
- `period` — input — PERIOD_W — auto step interval; one pulse every `period+1` cycles.
- `advance` — output — 1 — registered single-cycle advance pulse to `lights`.
- `state` — output — 2 — current FSM state encoding, for status/debug.

## Operation

- **Synchronizer:** two flops on `button_raw` produce `s`.
- **Debouncer:**
  - Holds a filtered level `db` and a counter `dcnt`.
  - If `s == db`: `dcnt <= 0`.
  - Else if `dcnt == DEBOUNCE-1`: `db <= s`, `dcnt <= 0`.
  - Else: `dcnt <= dcnt+1`.
  - `press` is a one-cycle pulse, equal to `db & ~db_q`, where `db_q` is `db` delayed by one cycle. Release events are ignored.
- **FSM states:** HOLD=`00`, MANUAL=`01`, AUTO_RUN=`10`, AUTO_PAUSE=`11`.
  - From any state, `mode` selects the next state:
    - hold or reserved → HOLD.
    - manual → MANUAL.
    - auto → AUTO_RUN when arriving from HOLD or MANUAL.
  - Within auto: `press` in AUTO_RUN → AUTO_PAUSE; `press` in AUTO_PAUSE → AUTO_RUN.
  - Mode changes take effect at the next edge. A `press` coinciding with a mode change is discarded.
- **Auto timer `tcnt`** (PERIOD_W bits):
  - Loads `period` on entry to AUTO_RUN, including resume from pause.
  - In AUTO_RUN: if `tcnt == 0`, assert the advance request and reload `period`; else decrement.
  - Frozen in AUTO_PAUSE.
  - `period` is sampled only at load/reload. `period == 0` gives a pulse every cycle.
- **advance** (registered):
  - Next value is 1 iff (MANUAL and `press`) or (AUTO_RUN and `tcnt == 0`).
  - Never high in HOLD or AUTO_PAUSE.
  - Never high for two consecutive cycles, except in AUTO_RUN with `period == 0`.
- A held button in MANUAL yields exactly one pulse; the button must release and re-press for the next.

## Timing

- **Reset values** (while `rst == 0`): `advance = 0`, `state = HOLD`, sync flops = 0, `db = 0`, `db_q = 0`, `dcnt = 0`, `tcnt = 0`. Reset may assert mid-operation; all state is lost with no pending pulse.
- **Press latency:** with edge k the first to sample `button_raw = 1` (held stable), `advance` is high for exactly the cycle after edge k+DEBOUNCE+2.
- **Glitch rejection:** any excursion of `s` shorter than DEBOUNCE samples leaves `db` unchanged.
- **Auto cadence:** with entry to AUTO_RUN at edge e, `advance` is high after edges e+period+1, e+2(period+1), and so on.
- **Pause/resume:** on pause, no pulse occurs after the pause edge. On resume, the first pulse comes period+1 cycles after the resume edge.

## Structure

- **Shared package `lights_pkg`:**
  - State enum (HOLD, MANUAL, AUTO_RUN, AUTO_PAUSE) with the encodings above.
  - Mode constants `MODE_HOLD`, `MODE_MANUAL`, `MODE_AUTO`.
  - Colour constants shared with `lights`.
- **Sub-module `button_debounce`:** synchronizer, debouncer and `press` edge detector; parameter DEBOUNCE; ports `clk`, `rst`, `button_raw`, `press`.
- **Top module:** contains the FSM, the auto timer and the advance register.

## Test plan

All scenarios use DEBOUNCE=4 and PERIOD_W=8.

1. Reset then release, `mode=01`, no button → `advance` stays 0 and `state=01`.
2. `mode=01`, `button_raw` rises at edge 10 and is held 20 cycles → `advance` high only in the cycle after edge 16; no further pulses until release and re-press.
3. `mode=01`, `button_raw` high for 3 edges then low → no `advance` pulse.
4. `mode=10`, `period=3`, entering AUTO_RUN at edge e → pulses after e+4, e+8 and e+12; changing `period` to 1 mid-interval takes effect only after the next pulse.
5. Auto running, valid press → `state=11` and no pulses for 50 cycles; second press → `state=10`, first pulse period+1 cycles after the resume edge.
6. `rst` asserted mid-count in AUTO_RUN, asynchronously between edges → `advance=0` and `state=00` immediately. After release with `mode=00` → no pulses.
